// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector.
//
// Holds the default pattern configuration, the state-width helper and the
// elaboration-time functions that turn a pattern into a complete next-state
// table (with KMP-style fallback on mismatch) and a match-complete table.
// Nothing in here produces runtime logic on its own; the detector indexes the
// resulting constant tables with its current state and input bit.
package seq_det_pkg;

  // Largest supported pattern; table sizes are fixed to this bound.
  localparam int MAX_LEN = 16;

  // Each table entry holds a state number 0..MAX_LEN-1.
  localparam int ENTRY_W = 4;

  // One entry per (state, input bit) pair.
  localparam int TABLE_W = MAX_LEN * 2 * ENTRY_W;
  localparam int DONE_W  = MAX_LEN * 2;

  // Default configuration: "101" with overlapping matches.
  localparam int         DEFAULT_LEN     = 3;
  localparam logic [2:0] DEFAULT_PATTERN = 3'b101;
  localparam bit         DEFAULT_OVERLAP = 1'b1;

  // Binary state width; a two-bit pattern still needs one state bit.
  function automatic int state_width(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

  // Bit i of the pattern in arrival order (i = 0 is the first bit received,
  // which is the MSB of the pattern value).
  function automatic logic pat_bit(input logic [MAX_LEN-1:0] pattern,
                                   input int                 len,
                                   input int                 i);
    return pattern[4'(len - 1 - i)];
  endfunction

  // Length of the longest pattern prefix, no longer than max_j, that is a
  // suffix of the string formed by the first k pattern bits followed by b.
  // max_j never exceeds k+1, so the string always covers the prefix tested.
  function automatic int longest_overlap(input logic [MAX_LEN-1:0] pattern,
                                         input int                 len,
                                         input int                 k,
                                         input logic               b,
                                         input int                 max_j);
    int   result;
    int   pos;
    logic ok;
    logic sb;
    result = 0;
    for (int j = 1; j <= MAX_LEN; j++) begin
      if (j <= max_j) begin
        ok = 1'b1;
        for (int t = 0; t < MAX_LEN; t++) begin
          if (t < j) begin
            pos = k + 1 - j + t;
            sb  = (pos == k) ? b : pat_bit(pattern, len, pos);
            if (sb != pat_bit(pattern, len, t)) ok = 1'b0;
          end
        end
        // Increasing j, so the last hit is the longest one.
        if (ok) result = j;
      end
    end
    return result;
  endfunction

  // Next-state table, entry (2*k + b) holds the state reached from Sk on bit b.
  // A completed match jumps to the longest proper border when overlapping,
  // otherwise back to S0. Rows for k >= len are unreachable and left at S0.
  function automatic logic [TABLE_W-1:0] build_next_table(
      input logic [MAX_LEN-1:0] pattern,
      input int                 len,
      input bit                 overlap);
    logic [TABLE_W-1:0] tbl;
    int                 nxt;
    logic               b;
    tbl = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      for (int bi = 0; bi < 2; bi++) begin
        b   = (bi != 0);
        nxt = 0;
        if (k < len) begin
          if (b == pat_bit(pattern, len, k)) begin
            if (k + 1 < len)  nxt = k + 1;
            else if (overlap) nxt = longest_overlap(pattern, len, k, b, len - 1);
            else              nxt = 0;
          end else begin
            nxt = longest_overlap(pattern, len, k, b, k);
          end
        end
        tbl[7'((2 * k + bi) * ENTRY_W) +: ENTRY_W] = ENTRY_W'(nxt);
      end
    end
    return tbl;
  endfunction

  // Match-complete table: bit (2*k + b) is set when bit b completes the
  // pattern from state Sk.
  function automatic logic [DONE_W-1:0] build_done_table(
      input logic [MAX_LEN-1:0] pattern,
      input int                 len);
    logic [DONE_W-1:0] tbl;
    tbl = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (k == len - 1) begin
        tbl[5'(2 * k + (pat_bit(pattern, len, k) ? 1 : 0))] = 1'b1;
      end
    end
    return tbl;
  endfunction

endpackage

// File: rtl/sequence_detector_3.sv
// Serial bit-stream pattern detector (Moore FSM).
//
// Samples one bit of seq on every rising clk edge and raises dout for one
// cycle on the edge that samples the final bit of PATTERN. State Sk means the
// longest suffix of the received stream that is also a prefix of PATTERN has
// length k; mismatches fall back KMP-style rather than restarting from S0.
//
// Parameters:
//   PATTERN_LEN  pattern length, 2..16
//   PATTERN      pattern value, MSB is the first bit received
//   OVERLAP      1: the tail of a match may start the next one; 0: restart
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset, highest priority
//   seq   in   serial data bit
//   dout  out  registered match flag
module sequence_detector_3
  import seq_det_pkg::*;
#(
  parameter int                     PATTERN_LEN = DEFAULT_LEN,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = DEFAULT_PATTERN,
  parameter bit                     OVERLAP     = DEFAULT_OVERLAP
) (
  input  logic clk,
  input  logic rst,
  input  logic seq,
  output logic dout
);

  localparam int SW = state_width(PATTERN_LEN);

  localparam logic [MAX_LEN-1:0] PATTERN_EXT = MAX_LEN'(PATTERN);

  // Full transition behaviour is resolved at elaboration; the FSM just looks
  // up (state, bit) in these constants.
  localparam logic [TABLE_W-1:0] NEXT_TABLE =
    build_next_table(PATTERN_EXT, PATTERN_LEN, OVERLAP);
  localparam logic [DONE_W-1:0]  DONE_TABLE =
    build_done_table(PATTERN_EXT, PATTERN_LEN);

  // States are numbered by matched-prefix length, so the count and encoding
  // follow PATTERN_LEN; S0 is the only state with a fixed meaning.
  typedef logic [SW-1:0] state_t;
  localparam state_t S0 = '0;

  state_t     state;
  state_t     next_state;
  logic       next_dout;
  logic [4:0] idx;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = S0;
    next_dout  = 1'b0;
    idx        = 5'({state, seq});
    next_state = state_t'(NEXT_TABLE[{idx, 2'b00} +: ENTRY_W]);
    next_dout  = DONE_TABLE[idx];
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S0;
      dout  <= 1'b0;
    end else begin
      state <= next_state;
      dout  <= next_dout;
    end
  end

endmodule

// File: tb/tb_sequence_detector_3.sv
// Testbench for sequence_detector_3.
//
// Four instances share clk/rst/seq:
//   0: default "101", overlapping
//   1: "101", non-overlapping
//   2: "1011", overlapping
//   3: "11", overlapping (back-to-back matches)
// The reference model keeps, per instance, a shift register of received bits
// and a count of bits since the last restart (reset, or a match when not
// overlapping); a match is the last LEN bits equalling the pattern with at
// least LEN bits since restart.
module tb_sequence_detector_3;

  logic       clk;
  logic       rst;
  logic       seq;
  logic [3:0] dout_all;

  int total = 0;
  int bad   = 0;

  int          cfg_len [4] = '{3, 3, 4, 2};
  logic [15:0] cfg_pat [4] = '{16'h0005, 16'h0005, 16'h000B, 16'h0003};
  bit          cfg_ovl [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  logic [15:0] m_sr  [4];
  int          m_cnt [4];
  logic        m_exp [4];

  sequence_detector_3 dut_a (
    .clk(clk), .rst(rst), .seq(seq), .dout(dout_all[0])
  );

  sequence_detector_3 #(.OVERLAP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .seq(seq), .dout(dout_all[1])
  );

  sequence_detector_3 #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) dut_c (
    .clk(clk), .rst(rst), .seq(seq), .dout(dout_all[2])
  );

  sequence_detector_3 #(.PATTERN_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1)) dut_d (
    .clk(clk), .rst(rst), .seq(seq), .dout(dout_all[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_update(input logic r, input logic b);
    logic [31:0] mask;
    logic        hit;
    for (int i = 0; i < 4; i++) begin
      if (r) begin
        m_cnt[i] = 0;
        m_exp[i] = 1'b0;
      end else begin
        m_sr[i]  = {m_sr[i][14:0], b};
        m_cnt[i] = m_cnt[i] + 1;
        mask     = (32'd1 << cfg_len[i]) - 32'd1;
        hit      = (m_cnt[i] >= cfg_len[i]) &&
                   (({16'd0, m_sr[i]} & mask) == {16'd0, cfg_pat[i]});
        m_exp[i] = hit;
        if (hit && !cfg_ovl[i]) m_cnt[i] = 0;
      end
    end
  endtask

  // Apply one clock edge, then sample 1 ns later.
  task automatic step(input logic r, input logic b);
    rst = r;
    seq = b;
    @(posedge clk);
    #1;
    model_update(r, b);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1);
      total++;
      if (dout_all !== 4'b0000) begin
        bad++;
        $display("FAIL reset edge%0d: dout=%b expected=0000", i + 1, dout_all);
      end
    end
    step(1'b0, 1'b0);
    total++;
    if (dout_all !== 4'b0000) begin
      bad++;
      $display("FAIL reset release: dout=%b expected=0000", dout_all);
    end
  endtask

  task automatic test_overlap();
    logic stim [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic want [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, stim[i]);
      total++;
      if (dout_all[0] !== want[i]) begin
        bad++;
        $display("FAIL overlap bit%0d: dout=%b expected=%b", i + 1, dout_all[0], want[i]);
      end
    end
  endtask

  task automatic test_no_overlap();
    logic stim [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic want [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, stim[i]);
      total++;
      if (dout_all[1] !== want[i]) begin
        bad++;
        $display("FAIL no_overlap bit%0d: dout=%b expected=%b", i + 1, dout_all[1], want[i]);
      end
    end
  endtask

  task automatic test_fallback();
    logic stim1 [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic want1 [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic stim2 [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic want2 [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, stim1[i]);
      total++;
      if (dout_all[0] !== want1[i]) begin
        bad++;
        $display("FAIL fallback_1101 bit%0d: dout=%b expected=%b", i + 1, dout_all[0], want1[i]);
      end
    end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, stim2[i]);
      total++;
      if (dout_all[0] !== want2[i]) begin
        bad++;
        $display("FAIL fallback_00101 bit%0d: dout=%b expected=%b", i + 1, dout_all[0], want2[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic rsts [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic stim [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic want [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(rsts[i], stim[i]);
      total++;
      if (dout_all[0] !== want[i]) begin
        bad++;
        $display("FAIL reset_mid step%0d: dout=%b expected=%b", i + 1, dout_all[0], want[i]);
      end
    end
  endtask

  task automatic test_len4();
    logic stim [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic want [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b0, stim[i]);
      total++;
      if (dout_all[2] !== want[i]) begin
        bad++;
        $display("FAIL len4_1011 bit%0d: dout=%b expected=%b", i + 1, dout_all[2], want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic stim [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic want [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, stim[i]);
      total++;
      if (dout_all[3] !== want[i]) begin
        bad++;
        $display("FAIL back_to_back_11 bit%0d: dout=%b expected=%b", i + 1, dout_all[3], want[i]);
      end
    end
  endtask

  task automatic test_random();
    logic r;
    logic b;
    int   hits;
    hits = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 63) == 0);
      b = 1'($urandom_range(0, 1));
      step(r, b);
      if (m_exp[0]) hits++;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (dout_all[i] !== m_exp[i]) begin
          bad++;
          $display("FAIL random dut%0d cycle%0d: dout=%b expected=%b", i, n, dout_all[i], m_exp[i]);
        end
      end
    end
    total++;
    if (hits == 0) begin
      bad++;
      $display("FAIL random_coverage: hits=%0d expected>0", hits);
    end
  endtask

  initial begin
    rst = 1'b1;
    seq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_sr[i]  = '0;
      m_cnt[i] = 0;
      m_exp[i] = 1'b0;
    end
    test_reset();
    test_overlap();
    test_no_overlap();
    test_fallback();
    test_reset_mid();
    test_len4();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
